// File: rtl/rptr_fwft_handler.sv
// Read-side pointer logic of the async FIFO: binary/Gray read pointer, empty flag,
// occupancy level with almost-empty, and a first-word-fall-through output register.
module rptr_fwft_handler #(
  parameter int PTR_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk_r,
  input  logic                  arst_n,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  dout_ready,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [PTR_WIDTH:0]    level,
  output logic                  almost_empty
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  // Handshake: a word moves to the consumer on any edge where dout_valid && dout_ready.
  // While dout_valid is high and dout_ready low, dout and dout_valid are held stable.
  // dout_ready only feeds flop inputs, so no output depends on it combinationally.

  logic          fetch;
  logic [PW-1:0] b_rptr_next;
  logic [PW-1:0] g_rptr_next;
  logic [PW-1:0] b_wptr_s;
  logic [PW-1:0] level_next;

  // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    b_wptr_s = '0;
    for (int i = 0; i < PW; i++) begin
      b_wptr_s[i] = ^(g_wptr_sync >> i);
    end
  end

  always_comb begin
    fetch       = !empty && (!dout_valid || dout_ready);
    b_rptr_next = b_rptr + {{(PW-1){1'b0}}, fetch};
    g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
    level_next  = b_wptr_s - b_rptr_next;
  end

  always_ff @(posedge clk_r or negedge arst_n) begin
    if (!arst_n) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      level        <= '0;
      almost_empty <= 1'b1;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      // Full-width compare keeps a completely full FIFO from aliasing to empty.
      empty        <= (g_rptr_next == g_wptr_sync);
      level        <= level_next;
      almost_empty <= (level_next <= AE_T);
    end
  end

  always_ff @(posedge clk_r or negedge arst_n) begin
    if (!arst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (fetch) begin
      dout       <= mem_rdata;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_fwft_handler.sv
// Self-checking bench for rptr_fwft_handler: the bench acts as writer and memory,
// and predicts outputs from word counts and a queue of written words.
module tb_rptr_fwft_handler;

  logic       clk_r = 1'b0;
  logic       arst_n;
  logic [3:0] g_wptr_sync;
  logic [7:0] mem_rdata;
  logic       dout_ready;
  logic [3:0] b_rptr, g_rptr, level;
  logic       empty, dout_valid, almost_empty;
  logic [7:0] dout;

  logic [7:0] mem [8];
  logic [3:0] wptr;
  logic [7:0] exp_q[$];

  logic [3:0] m_rd, m_level;
  logic       m_empty, m_v, m_ae;
  logic [7:0] m_dout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [22:0] dut_vec;

  rptr_fwft_handler #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AE_THRESH(1)) dut (
    .clk_r(clk_r), .arst_n(arst_n), .g_wptr_sync(g_wptr_sync), .mem_rdata(mem_rdata),
    .dout_ready(dout_ready), .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty),
    .dout(dout), .dout_valid(dout_valid), .level(level), .almost_empty(almost_empty)
  );

  always #5 clk_r = ~clk_r;

  assign mem_rdata = mem[b_rptr[2:0]];
  assign dut_vec   = {b_rptr, g_rptr, empty, dout, dout_valid, level, almost_empty};

  function automatic logic [22:0] exp_vec();
    logic [3:0] g;
    g = m_rd ^ (m_rd >> 1);
    return {m_rd, g, m_empty, m_dout, m_v, m_level, m_ae};
  endfunction

  task automatic model_reset();
    m_rd = 0; m_level = 0; m_empty = 1; m_v = 0; m_ae = 1; m_dout = 0;
    wptr = 0; g_wptr_sync = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    arst_n = 0;
    dout_ready = 0;
    model_reset();
    @(posedge clk_r); @(posedge clk_r); #1;
    arst_n = 1;
  endtask

  // Writer side: store a word, then publish the advanced write pointer in Gray.
  task automatic push_word(input logic [7:0] d);
    mem[wptr[2:0]] = d;
    exp_q.push_back(d);
    wptr = wptr + 4'd1;
    g_wptr_sync = wptr ^ (wptr >> 1);
  endtask

  // One clock: the model sees the same inputs as the DUT at this edge.
  task automatic step(input logic rdy);
    logic nf;
    dout_ready = rdy;
    nf = !m_empty && (!m_v || rdy);
    if (nf) begin
      m_dout = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      m_v = 1;
    end else if (rdy) begin
      m_v = 0;
    end
    m_rd    = m_rd + {3'd0, nf};
    m_level = wptr - m_rd;
    m_empty = (m_rd == wptr);
    m_ae    = (m_level <= 4'd1);
    @(posedge clk_r); #1;
  endtask

  task automatic test_reset();
    do_reset();
    push_word(8'h3C); push_word(8'h7E);
    step(0); step(0);
    n_checks++;
    if (dout_valid !== 1'b1) $display("FAIL reset_pre valid=%b want 1", dout_valid);
    else n_pass++;
    #2 arst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_async got=%h want=%h", dut_vec, exp_vec());
    else n_pass++;
    arst_n = 1;
    step(0);
    n_checks++;
    if ({empty, dout_valid, level, almost_empty} !== {1'b1, 1'b0, 4'd0, 1'b1})
      $display("FAIL reset_release e=%b v=%b lvl=%0d ae=%b want 1 0 0 1", empty, dout_valid, level, almost_empty);
    else n_pass++;
  endtask

  task automatic test_single_word();
    do_reset();
    push_word(8'hA5);
    step(0);
    n_checks++;
    if ({empty, level} !== {1'b0, 4'd1}) $display("FAIL single_e1 e=%b lvl=%0d want 0 1", empty, level);
    else n_pass++;
    step(0);
    n_checks++;
    if ({dout, dout_valid, b_rptr, g_rptr, empty, level} !== {8'hA5, 1'b1, 4'd1, 4'b0001, 1'b1, 4'd0})
      $display("FAIL single_e2 got=%h want=%h", {dout, dout_valid, b_rptr, g_rptr, empty, level},
               {8'hA5, 1'b1, 4'd1, 4'b0001, 1'b1, 4'd0});
    else n_pass++;
    step(1);
    n_checks++;
    if (dout_valid !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL single_consume got=%h want=%h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [3:0] gtab [5];
    logic [7:0] w [4];
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      push_word(w[i]);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++;
      if (b_rptr !== 4'(i) || g_rptr !== gtab[i] || level !== 4'(4 - i) ||
          almost_empty !== ((4 - i) <= 1) || dout_valid !== (i > 0) ||
          (i > 0 && dout !== w[(i > 0) ? i - 1 : 0]))
        $display("FAIL stream_%0d b=%0d g=%b lvl=%0d ae=%b v=%b d=%h want b=%0d g=%b lvl=%0d",
                 i, b_rptr, g_rptr, level, almost_empty, dout_valid, dout, i, gtab[i], 4 - i);
      else n_pass++;
    end
    step(1);
    n_checks++;
    if (dout_valid !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL stream_end got=%h want=%h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] w [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      push_word(w[i]);
    end
    step(0); step(0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({dout, dout_valid, b_rptr, level} !== {w[0], 1'b1, 4'd1, 4'd2})
        $display("FAIL bp_hold_%0d d=%h v=%b b=%0d lvl=%0d want %h 1 1 2", k, dout, dout_valid, b_rptr, level, w[0]);
      else n_pass++;
      step(0);
    end
    for (int i = 1; i < 3; i++) begin
      step(1);
      n_checks++;
      if (dout !== w[i] || dout_valid !== 1'b1 || dut_vec !== exp_vec())
        $display("FAIL bp_drain_%0d got=%h want=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    step(1);
    n_checks++;
    if (dout_valid !== 1'b0 || dout !== w[2] || empty !== 1'b1)
      $display("FAIL bp_stale v=%b d=%h e=%b want 0 %h 1", dout_valid, dout, empty, w[2]);
    else n_pass++;
  endtask

  task automatic test_full_and_wrap();
    logic [3:0] occ;
    int pushed;
    logic saw8;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'($urandom_range(0, 255)));
    step(0);
    n_checks++;
    if ({g_wptr_sync, level, almost_empty, empty, b_rptr} !== {4'b1100, 4'd8, 1'b0, 1'b0, 4'd0})
      $display("FAIL full_depth lvl=%0d ae=%b e=%b b=%0d want 8 0 0 0", level, almost_empty, empty, b_rptr);
    else n_pass++;
    pushed = 0;
    saw8 = 0;
    for (int c = 0; c < 24; c++) begin
      occ = wptr - m_rd;
      if (pushed < 8 && occ < 4'd8) begin
        push_word(8'($urandom_range(0, 255)));
        pushed++;
      end
      step(1);
      if (b_rptr === 4'd8) saw8 = 1;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL wrap_cyc%0d got=%h want=%h", c, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (saw8 !== 1'b1 || b_rptr !== 4'd0 || empty !== 1'b1 || exp_q.size() != 0)
      $display("FAIL wrap_end saw8=%b b=%0d e=%b left=%0d want 1 0 1 0", saw8, b_rptr, empty, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] occ;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      occ = wptr - m_rd;
      if (occ < 4'd8 && $urandom_range(0, 1) == 1) push_word(8'($urandom_range(0, 255)));
      step(1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL random_cyc%0d got=%h want=%h", c, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    arst_n = 0;
    dout_ready = 0;
    g_wptr_sync = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_full_and_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rptr_fwft_handler.md
Name: rptr_fwft_handler

Overview:
- Read-side pointer and output stage of the async FIFO, in the read clock domain.
- It is the counterpart of the write-pointer handler: it consumes the write pointer after that pointer is Gray-coded and synchronised into the read domain.
- It produces the binary read pointer (memory address) and the Gray read pointer, which goes back to the write domain for the full check.
- It adds a first-word-fall-through (FWFT) output register with a valid/ready handshake, plus an occupancy level and an almost-empty flag.

Parameters:
- PTR_WIDTH, 3: address bits. FIFO depth is 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits (extra wrap bit).
- DATA_WIDTH, 8: width of a FIFO word.
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH. Legal range is 0 .. 2**PTR_WIDTH.

Ports:
- clk_r  in  1  read-domain clock.
- arst_n  in  1  asynchronous active-low reset.
- g_wptr_sync  in  PTR_WIDTH+1  write pointer, Gray-coded, already 2-flop synchronised into clk_r.
- mem_rdata  in  DATA_WIDTH  combinational memory read data at address b_rptr[PTR_WIDTH-1:0].
- dout_ready  in  1  consumer accepts dout this cycle.
- b_rptr  out  PTR_WIDTH+1  binary read pointer. The low PTR_WIDTH bits are the memory read address.
- g_rptr  out  PTR_WIDTH+1  Gray read pointer, registered, for the write-domain synchroniser.
- empty  out  1  registered: no word is pending in memory (the output register may still hold one).
- dout  out  DATA_WIDTH  FWFT output data.
- dout_valid  out  1  dout holds a valid word.
- level  out  PTR_WIDTH+1  registered count of words in memory not yet fetched. Range 0 .. 2**PTR_WIDTH.
- almost_empty  out  1  registered: level <= AE_THRESH.

Behaviour:
- Single clock clk_r. Reset is asynchronous and active-low (arst_n).
- Every flop responds to arst_n low immediately, independent of clk_r.
- Reset values:
  - b_rptr = 0, g_rptr = 0, empty = 1, dout = 0, dout_valid = 0, level = 0, almost_empty = 1.
- Fetch condition:
  - fetch = !empty && (!dout_valid || dout_ready).
- Read pointer:
  - b_rptr_next = b_rptr + fetch, wrapping modulo 2**(PTR_WIDTH+1).
  - g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next.
  - Both registered each edge; g_rptr changes by at most one bit per cycle.
- Empty:
  - empty <= (g_rptr_next == g_wptr_sync), with the full PTR_WIDTH+1-bit compare.
- Output register, per edge, in priority order:
  - If fetch: dout <= mem_rdata and dout_valid <= 1.
  - Else if dout_ready: dout_valid <= 0, and dout holds its last value.
  - Else: hold dout and dout_valid.
- Handshake:
  - A transfer occurs when dout_valid && dout_ready.
  - While dout_valid=1 and dout_ready=0, dout and dout_valid stay stable.
  - Back-to-back transfers sustain 1 word per cycle while words are available.
- Latency:
  - g_wptr_sync changes before edge E. At edge E, empty goes low.
  - At edge E+1, dout_valid goes high with the oldest word.
- Level:
  - b_wptr_s = Gray-to-binary of g_wptr_sync (MSB copy, then XOR prefix downward).
  - level <= b_wptr_s - b_rptr_next, modulo 2**(PTR_WIDTH+1).
  - level excludes the word held in dout.
  - almost_empty <= (b_wptr_s - b_rptr_next) <= AE_THRESH.
- Boundaries:
  - Pointer wrap: after 2**PTR_WIDTH fetches the MSB toggles. empty compares the full pointer, so 8 words never read as empty.
  - A fetch of the last word sets empty=1 on the same edge as dout_valid=1. No further fetch happens until g_wptr_sync advances.
  - Simultaneous consume and empty=1: dout_valid falls, and dout keeps stale data.
  - Simultaneous consume and fetch: dout is replaced, and dout_valid stays 1.
  - Reset mid-operation: the pending dout word is discarded, and all outputs return to reset values.
  - The write domain must be reset together with this block.
- No combinational path from dout_ready to any output.

Test Plan:
- Reset: drive arst_n=0 mid-stream with dout_valid=1 -> all outputs at reset values immediately, without waiting for a clk_r edge. After release with g_wptr_sync=0: empty=1, dout_valid=0, level=0, almost_empty=1.
- Single word (PTR_WIDTH=3): g_wptr_sync 0000→0001, memory[0]=0xA5.
  - Next edge: empty=0, level=1.
  - Following edge: dout=0xA5, dout_valid=1, b_rptr=1, g_rptr=0001, empty=1, level=0.
  - With dout_ready=1 one cycle later: dout_valid=0.
- Streaming: g_wptr_sync=0110 (binary 4), dout_ready held 1 -> 4 consecutive cycles of dout_valid=1 carrying mem[0..3].
  - b_rptr steps 1,2,3,4 and g_rptr steps 0001,0011,0010,0110.
  - level steps 4,3,2,1,0; almost_empty rises when level<=1.
- Backpressure: 3 words available, dout_ready=0 -> first word held stable on dout, b_rptr=1, level=2. Releasing dout_ready drains the remaining 2 words on consecutive cycles.
- Wrap: 8 writes read out, then 8 more (g_wptr_sync reaches 1000 for binary 15 then 0000 at 16) -> b_rptr passes 0111→1000, and empty stays 0 while 8 words are pending.
  - mem addresses wrap 7→0, and dout order is preserved.
  - At 16 fetches: b_rptr=0000, empty=1.
- Full depth: g_wptr_sync=1100 (binary 8) with b_rptr=0 -> level=8, almost_empty=0 (AE_THRESH=1), empty=0.
